// File: rtl/pipe_fetch_stage.sv
// Three-state instruction fetch stage (BOOT/RUN/HALT) with fetch, decode and
// execute instruction registers. Optional stall counter: PIPE_STALL_CNT_EN.
module pipe_fetch_stage #(
  parameter int          PC_W = 8,
  parameter logic [15:0] NOP  = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            imem_valid,
  input  logic            chazard,
  input  logic            dhazard,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ifir,
  output logic [15:0]     idir,
  output logic [15:0]     exir,
  output logic            drained
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  // Branch target comes from the low byte of ifir, zero-extended for wide PCs.
  localparam int TW = (PC_W > 8) ? 8 : PC_W;

  state_e          state_q;
  logic            req_q;
  logic [PC_W-1:0] pc_q, pc_d, tgt;
  logic [15:0]     ifir_q, ifir_d, idir_q, idir_d, exir_q, exir_d;

  assign tgt = PC_W'(ifir_q[TW-1:0]);

  always_comb begin
    pc_d   = pc_q;
    ifir_d = ifir_q;
    idir_d = idir_q;
    exir_d = exir_q;
    case (state_q)
      RUN: begin
        if (dhazard) begin
          idir_d = NOP;
          exir_d = idir_q;
        end else if (chazard) begin
          pc_d   = tgt;
          ifir_d = NOP;
          idir_d = ifir_q;
          exir_d = idir_q;
        end else if (!imem_valid) begin
          ifir_d = NOP;
          idir_d = ifir_q;
          exir_d = idir_q;
        end else begin
          pc_d   = pc_q + PC_W'(1);
          ifir_d = imem_data;
          idir_d = ifir_q;
          exir_d = idir_q;
        end
      end
      HALT: begin
        ifir_d = NOP;
        idir_d = ifir_q;
        exir_d = idir_q;
      end
      default: ;
    endcase
  end

  // imem_req is registered alongside the state so it tracks the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          req_q   <= 1'b1;
        end
        RUN: if (halt_i) begin
          state_q <= HALT;
          req_q   <= 1'b0;
        end
        HALT: if (!halt_i) begin
          state_q <= RUN;
          req_q   <= 1'b1;
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      ifir_q <= NOP;
      idir_q <= NOP;
      exir_q <= NOP;
    end else begin
      pc_q   <= pc_d;
      ifir_q <= ifir_d;
      idir_q <= idir_d;
      exir_q <= exir_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ifir      = ifir_q;
  assign idir      = idir_q;
  assign exir      = exir_q;
  assign drained   = (state_q == HALT) && (idir_q == NOP) && (exir_q == NOP);

`ifdef PIPE_STALL_CNT_EN
  logic        stall_evt;
  logic [15:0] scnt_q;

  assign stall_evt = (state_q == RUN) && (dhazard || !imem_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                scnt_q <= '0;
    else if (stall_evt && scnt_q != 16'hFFFF)  scnt_q <= scnt_q + 16'd1;
  end

  assign stall_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed-vector scoreboard bench for pipe_fetch_stage: the driver queues the
// hand-computed post-edge state, a monitor pops and compares after each edge.
module tb_pipe_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic        imem_valid = 1'b0;
  logic        chazard = 1'b0;
  logic        dhazard = 1'b0;
  logic        halt_i = 1'b0;
  logic [7:0]  pc;
  logic [15:0] ifir, idir, exir;
  logic        drained;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pipe_fetch_stage #(.PC_W(8), .NOP(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .chazard(chazard), .dhazard(dhazard), .halt_i(halt_i),
    .pc(pc), .ifir(ifir), .idir(idir), .exir(exir), .drained(drained)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [7:0]  pc;
    logic [15:0] ifr, idr, exr;
    logic        req, drn;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
  endtask

  // Inputs for one cycle plus the expected outputs after the following edge.
  task automatic step(input int id, input logic dh, input logic ch, input logic hl,
                      input logic v, input logic [15:0] d,
                      input logic [7:0] e_pc, input logic [15:0] e_if, input logic [15:0] e_id,
                      input logic [15:0] e_ex, input logic e_req, input logic e_drn);
    exp_t e;
    @(negedge clk);
    dhazard = dh; chazard = ch; halt_i = hl; imem_valid = v; imem_data = d;
    e.id = id; e.pc = e_pc; e.ifr = e_if; e.idr = e_id; e.exr = e_ex;
    e.req = e_req; e.drn = e_drn;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc",        e.id, 32'(pc),        32'(e.pc));
      chk("imem_addr", e.id, 32'(imem_addr), 32'(e.pc));
      chk("ifir",      e.id, 32'(ifir),      32'(e.ifr));
      chk("idir",      e.id, 32'(idir),      32'(e.idr));
      chk("exir",      e.id, 32'(exir),      32'(e.exr));
      chk("imem_req",  e.id, 32'(imem_req),  32'(e.req));
      chk("drained",   e.id, 32'(drained),   32'(e.drn));
    end
  end

  task automatic chk_reset(input int id);
    chk("rst_pc",   id, 32'(pc),       32'h0);
    chk("rst_ifir", id, 32'(ifir),     32'h0);
    chk("rst_idir", id, 32'(idir),     32'h0);
    chk("rst_exir", id, 32'(exir),     32'h0);
    chk("rst_req",  id, 32'(imem_req), 32'h0);
    chk("rst_drn",  id, 32'(drained),  32'h0);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_scnt", id, 32'(stall_cnt), 32'h0);
`endif
  endtask

  task automatic release_reset(input int id);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("boot_req", id, 32'(imem_req), 32'h0);
    chk("boot_pc",  id, 32'(pc),       32'h0);
  endtask

  initial begin
    #2;
    chk_reset(900);
    release_reset(901);
    //      id dh ch hl v  data       pc     ifir      idir      exir      req drn
    step( 0, 0, 0, 0, 1, 16'h1111, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0);
    step( 1, 0, 0, 0, 1, 16'h1111, 8'h01, 16'h1111, 16'h0000, 16'h0000, 1, 0);
    step( 2, 0, 0, 0, 1, 16'h2222, 8'h02, 16'h2222, 16'h1111, 16'h0000, 1, 0);
    step( 3, 0, 0, 0, 1, 16'h3333, 8'h03, 16'h3333, 16'h2222, 16'h1111, 1, 0);
    step( 4, 1, 0, 0, 1, 16'h4444, 8'h03, 16'h3333, 16'h0000, 16'h2222, 1, 0);
    step( 5, 0, 0, 0, 1, 16'h4444, 8'h04, 16'h4444, 16'h3333, 16'h0000, 1, 0);
    step( 6, 0, 0, 0, 1, 16'hC012, 8'h05, 16'hC012, 16'h4444, 16'h3333, 1, 0);
    step( 7, 0, 1, 0, 1, 16'h5555, 8'h12, 16'h0000, 16'hC012, 16'h4444, 1, 0);
    step( 8, 1, 1, 0, 1, 16'h6666, 8'h12, 16'h0000, 16'h0000, 16'hC012, 1, 0);
    step( 9, 0, 0, 0, 1, 16'h00FF, 8'h13, 16'h00FF, 16'h0000, 16'h0000, 1, 0);
    step(10, 0, 1, 0, 1, 16'h7777, 8'hFF, 16'h0000, 16'h00FF, 16'h0000, 1, 0);
    step(11, 0, 0, 0, 1, 16'h8888, 8'h00, 16'h8888, 16'h0000, 16'h00FF, 1, 0);
    step(12, 0, 0, 0, 0, 16'hDEAD, 8'h00, 16'h0000, 16'h8888, 16'h0000, 1, 0);
    step(13, 0, 0, 0, 0, 16'hDEAD, 8'h00, 16'h0000, 16'h0000, 16'h8888, 1, 0);
    step(14, 0, 0, 0, 1, 16'h9999, 8'h01, 16'h9999, 16'h0000, 16'h0000, 1, 0);
    step(15, 0, 0, 0, 1, 16'hAAAA, 8'h02, 16'hAAAA, 16'h9999, 16'h0000, 1, 0);
    step(16, 0, 0, 1, 1, 16'hBBBB, 8'h03, 16'hBBBB, 16'hAAAA, 16'h9999, 0, 0);
    step(17, 1, 0, 1, 1, 16'h1234, 8'h03, 16'h0000, 16'hBBBB, 16'hAAAA, 0, 0);
    step(18, 0, 1, 1, 1, 16'h1234, 8'h03, 16'h0000, 16'h0000, 16'hBBBB, 0, 0);
    step(19, 0, 0, 1, 1, 16'h1234, 8'h03, 16'h0000, 16'h0000, 16'h0000, 0, 1);
    step(20, 0, 0, 0, 1, 16'h1234, 8'h03, 16'h0000, 16'h0000, 16'h0000, 1, 0);
    step(21, 0, 0, 0, 1, 16'hCCCC, 8'h04, 16'hCCCC, 16'h0000, 16'h0000, 1, 0);
    step(22, 0, 0, 0, 1, 16'hC0A5, 8'h05, 16'hC0A5, 16'hCCCC, 16'h0000, 1, 0);
    step(23, 0, 1, 1, 1, 16'hDDDD, 8'hA5, 16'h0000, 16'hC0A5, 16'hCCCC, 0, 0);
    step(24, 0, 0, 0, 1, 16'hDDDD, 8'hA5, 16'h0000, 16'h0000, 16'hC0A5, 1, 0);
    step(25, 0, 0, 0, 1, 16'hEEEE, 8'hA6, 16'hEEEE, 16'h0000, 16'h0000, 1, 0);
    @(posedge clk); #2;
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt_a", 25, 32'(stall_cnt), 32'd4);
`endif
    // Reset in the middle of a redirect: nothing may survive.
    @(negedge clk);
    dhazard = 1'b0; chazard = 1'b1; halt_i = 1'b0; imem_valid = 1'b1; imem_data = 16'hFACE;
    #2 rst_n = 1'b0;
    #1 chk_reset(902);
    @(posedge clk); #1;
    chk_reset(903);
    chazard = 1'b0;
    release_reset(904);
    step(30, 0, 0, 0, 1, 16'h1234, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 0);
    step(31, 0, 0, 0, 1, 16'h1234, 8'h01, 16'h1234, 16'h0000, 16'h0000, 1, 0);
    step(32, 1, 0, 0, 1, 16'h5678, 8'h01, 16'h1234, 16'h0000, 16'h0000, 1, 0);
    step(33, 1, 0, 0, 1, 16'h5678, 8'h01, 16'h1234, 16'h0000, 16'h0000, 1, 0);
    step(34, 1, 1, 0, 1, 16'h5678, 8'h01, 16'h1234, 16'h0000, 16'h0000, 1, 0);
    step(35, 1, 0, 0, 0, 16'h5678, 8'h01, 16'h1234, 16'h0000, 16'h0000, 1, 0);
    step(36, 1, 0, 0, 1, 16'h5678, 8'h01, 16'h1234, 16'h0000, 16'h0000, 1, 0);
    step(37, 0, 0, 0, 0, 16'h5678, 8'h01, 16'h0000, 16'h1234, 16'h0000, 1, 0);
    step(38, 0, 0, 0, 0, 16'h5678, 8'h01, 16'h0000, 16'h0000, 16'h1234, 1, 0);
    @(negedge clk);
    imem_valid = 1'b1; halt_i = 1'b1;
    @(posedge clk); #2;
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt_b", 38, 32'(stall_cnt), 32'd7);
`endif
    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", 999, 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_stage.md
PIPE_FETCH_STAGE -- requirements
Module: pipe_fetch_stage

Interface
REQ-001 Parameter PC_W, default 8, program-counter and instruction-memory address width.
REQ-002 Parameter NOP, default 16'h0000, bubble word injected on stall, flush or fetch miss.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  PC_W  fetch address; always equals pc.
REQ-007 imem_data  input  16  fetched instruction word.
REQ-008 imem_valid  input  1  imem_data is valid this cycle; sampled only while imem_req=1.
REQ-009 chazard  input  1  control hazard: the branch in ifir is taken.
REQ-010 dhazard  input  1  data hazard: stall fetch, bubble decode.
REQ-011 halt_i  input  1  stop fetching and drain the pipeline.
REQ-012 pc  output  PC_W  current fetch address.
REQ-013 ifir, idir, exir  output  16 each  fetch, decode and execute instruction registers.
REQ-014 drained  output  1  high when the state is HALT and idir==NOP and exir==NOP.

Function
REQ-015 The FSM SHALL have three states: BOOT, RUN and HALT. Reset enters BOOT.
REQ-016 BOOT SHALL hold imem_req=0 for exactly one cycle, then go to RUN.
REQ-017 In RUN, imem_req=1. The FSM SHALL go to HALT when halt_i=1 and to RUN from HALT when halt_i=0.
REQ-018 In HALT, imem_req=0 and pc holds. ifir<=NOP, idir<=ifir, exir<=idir each cycle, so the pipeline drains in 3 cycles.
REQ-019 Update priority in RUN SHALL be dhazard, then chazard, then !imem_valid, then normal.
REQ-020 dhazard=1: pc and ifir hold, idir<=NOP, exir<=idir.
REQ-021 chazard=1 (dhazard=0): pc<=ifir[PC_W-1:0] (zero-extended if PC_W>8), ifir<=NOP (the fetched word is discarded), idir<=ifir, exir<=idir.
REQ-022 imem_valid=0 (no hazard): pc holds, ifir<=NOP, idir<=ifir, exir<=idir.
REQ-023 Normal fetch: pc<=pc+1 modulo 2^PC_W (wraps from all-ones to 0), ifir<=imem_data, idir<=ifir, exir<=idir.
REQ-024 Both hazards asserted together SHALL act as dhazard only. Hazard inputs SHALL be ignored in BOOT and HALT.
REQ-025 halt_i and chazard in the same RUN cycle: the redirect SHALL complete (pc<=target) and the next state is HALT.
REQ-026 Fetch latency: imem_data presented with imem_valid=1 in cycle N SHALL appear on ifir after edge N, on idir after N+1 and on exir after N+2, absent stalls.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously set state=BOOT, pc=0, ifir=idir=exir=NOP, imem_req=0 and drained=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; no partial update may survive.

Configuration
REQ-029 With macro PIPE_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits).
- Counts RUN cycles in which dhazard=1 or imem_valid=0.
- Saturates at 16'hFFFF.
- Reset value 0.
REQ-030 With PIPE_STALL_CNT_EN undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset release, imem_valid=1, words A,B,C -> BOOT 1 cycle; pc 0,1,2,3; exir=A three cycles after A is fetched.
REQ-032 dhazard=1 for 1 cycle with ifir=B, idir=A -> pc and ifir=B hold; idir=NOP, exir=A; B resumes the next cycle.
REQ-033 ifir=16'hC012 with chazard=1 -> pc=8'h12, ifir=NOP, idir=16'hC012 next cycle.
REQ-034 pc=8'hFF with a normal fetch -> pc=8'h00; imem_valid=0 for 2 cycles -> two NOPs in ifir, pc held.
REQ-035 halt_i=1 during RUN -> imem_req=0 and drained=1 after 3 cycles; halt_i=0 -> RUN resumes at the held pc.
REQ-036 PIPE_STALL_CNT_EN defined, 5 dhazard cycles and 2 miss cycles -> stall_cnt=7; rst_n=0 mid-sequence -> stall_cnt=0 and all IRs=NOP immediately.
